// File: rtl/pmp_seq_checker_if.sv
// Request/response and PMP configuration bundle for pmp_seq_checker.
interface pmp_seq_checker_if #(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16
);
    logic                          req_valid_i;
    logic                          req_ready_o;
    logic [PLEN-1:0]               addr_i;
    logic [2:0]                    access_i;
    logic [1:0]                    priv_i;
    logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i;
    logic [NR_ENTRIES*8-1:0]       conf_i;
    logic                          flush_i;
    logic                          rsp_valid_o;
    logic                          rsp_ready_i;
    logic                          allow_o;
    logic                          matched_o;
    logic [3:0]                    match_idx_o;

    modport master (
        output req_valid_i, addr_i, access_i, priv_i, conf_addr_i, conf_i, flush_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, allow_o, matched_o, match_idx_o
    );

    modport slave (
        input  req_valid_i, addr_i, access_i, priv_i, conf_addr_i, conf_i, flush_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, allow_o, matched_o, match_idx_o
    );
endinterface

// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: one shared address-match datapath walks the entries one per cycle.
// Define PMP_SEQ_EARLY_EXIT_EN to stop scanning at the first matching entry.

// Single-entry PMP address match (TOR / NA4 / NAPOT) on word addresses.
module pmp_entry #(
    parameter int unsigned PLEN    = 56,
    parameter int unsigned PMP_LEN = 54
) (
    input  logic [PLEN-3:0]    addr_word,
    input  logic [PMP_LEN-1:0] conf_addr,
    input  logic [PMP_LEN-1:0] prev_addr,
    input  logic [1:0]         mode,
    output logic               match
);
    localparam int unsigned WW = PLEN - 2;

    logic [WW-1:0] cur_w;
    logic [WW-1:0] prev_w;
    logic [WW-1:0] napot_mask;

    always_comb begin
        cur_w      = WW'(conf_addr);
        prev_w     = WW'(prev_addr);
        // trailing ones of pmpaddr plus the next bit form the don't-care region
        napot_mask = cur_w ^ (cur_w + WW'(1));
        match      = 1'b0;
        case (mode)
            2'b01:   match = (addr_word >= prev_w) && (addr_word < cur_w);
            2'b10:   match = (addr_word == cur_w);
            2'b11:   match = ((addr_word ^ cur_w) & ~napot_mask) == '0;
            default: match = 1'b0;
        endcase
    end
endmodule

module pmp_seq_checker #(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    pmp_seq_checker_if.slave  bus
);
    localparam int unsigned WW          = PLEN - 2;
    localparam int unsigned MAX_ENTRIES = 16;
    localparam logic [3:0]  LAST_IDX    = 4'(NR_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [WW-1:0] addr_q, addr_d;
    logic [2:0]    access_q, access_d;
    logic [1:0]    priv_q, priv_d;
    logic          hit_q, hit_d;
    logic [3:0]    hit_idx_q, hit_idx_d;
    logic          hit_allow_q, hit_allow_d;
    logic          allow_q, allow_d;
    logic          matched_q, matched_d;
    logic [3:0]    match_idx_q, match_idx_d;

    logic [PMP_LEN-1:0] entry_addr [MAX_ENTRIES];
    logic [7:0]         entry_cfg  [MAX_ENTRIES];
    logic [PMP_LEN-1:0] cur_addr;
    logic [PMP_LEN-1:0] prev_addr;
    logic [7:0]         cur_cfg;
    logic               entry_match;
    logic               entry_allow;
    logic               priv_m;
    logic               scan_done;
    logic               unused_bits;

    // Unpack the live configuration; slots beyond NR_ENTRIES read as OFF.
    for (genvar k = 0; k < MAX_ENTRIES; k++) begin : g_entry
        if (k < NR_ENTRIES) begin : g_used
            assign entry_addr[k] = bus.conf_addr_i[k*PMP_LEN +: PMP_LEN];
            assign entry_cfg[k]  = bus.conf_i[k*8 +: 8];
        end else begin : g_pad
            assign entry_addr[k] = '0;
            assign entry_cfg[k]  = '0;
        end
    end

    assign cur_addr  = entry_addr[idx_q];
    assign prev_addr = (idx_q == 4'd0) ? '0 : entry_addr[idx_q - 4'd1];
    assign cur_cfg   = entry_cfg[idx_q];

    pmp_entry #(.PLEN(PLEN), .PMP_LEN(PMP_LEN)) u_entry (
        .addr_word (addr_q),
        .conf_addr (cur_addr),
        .prev_addr (prev_addr),
        .mode      (cur_cfg[4:3]),
        .match     (entry_match)
    );

    assign priv_m      = (priv_q == 2'b11);
    assign entry_allow = (priv_m && !cur_cfg[7]) || ((access_q & cur_cfg[2:0]) == access_q);

`ifdef PMP_SEQ_EARLY_EXIT_EN
    assign scan_done = (idx_q == LAST_IDX) || entry_match;
`else
    assign scan_done = (idx_q == LAST_IDX);
`endif

    assign unused_bits = ^{bus.addr_i[1:0], cur_cfg[6:5]};

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.allow_o     = allow_q;
    assign bus.matched_o   = matched_q;
    assign bus.match_idx_o = match_idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            access_q    <= '0;
            priv_q      <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            hit_allow_q <= 1'b0;
            allow_q     <= 1'b0;
            matched_q   <= 1'b0;
            match_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            access_q    <= access_d;
            priv_q      <= priv_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            hit_allow_q <= hit_allow_d;
            allow_q     <= allow_d;
            matched_q   <= matched_d;
            match_idx_q <= match_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        access_d    = access_q;
        priv_d      = priv_q;
        hit_d       = hit_q;
        hit_idx_d   = hit_idx_q;
        hit_allow_d = hit_allow_q;
        allow_d     = allow_q;
        matched_d   = matched_q;
        match_idx_d = match_idx_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i && !bus.flush_i) begin
                    addr_d      = bus.addr_i[PLEN-1:2];
                    access_d    = bus.access_i;
                    priv_d      = bus.priv_i;
                    idx_d       = '0;
                    hit_d       = 1'b0;
                    hit_idx_d   = '0;
                    hit_allow_d = 1'b0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    // only the lowest-index match is kept
                    if (entry_match && !hit_q) begin
                        hit_d       = 1'b1;
                        hit_idx_d   = idx_q;
                        hit_allow_d = entry_allow;
                    end
                    if (scan_done) begin
                        state_d     = RESP;
                        matched_d   = hit_d;
                        match_idx_d = hit_d ? hit_idx_d : 4'd0;
                        allow_d     = hit_d ? hit_allow_d : priv_m;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            RESP: begin
                if (bus.flush_i || bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
